// File: rtl/wb_psram_pkg.sv
// Shared types and sizing for the wb_psram Wishbone-to-CellularRAM bridge.
// The CFG_* states exist only when WB_PSRAM_CRE_INIT_EN is defined.
package wb_psram_pkg;

    localparam int HW_COUNT = 2;
    localparam int HW_W     = $clog2(HW_COUNT);
    localparam int ADR_W    = 23;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_STROBE     = 3'd2,
        ST_HOLD       = 3'd3,
        ST_ACK        = 3'd4
`ifdef WB_PSRAM_CRE_INIT_EN
        ,
        ST_CFG_SETUP  = 3'd5,
        ST_CFG_STROBE = 3'd6,
        ST_CFG_HOLD   = 3'd7
`endif
    } state_e;

    // Wide enough to hold the larger strobe length loaded into the down-counter.
    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wb_psram_if.sv
// Wishbone classic slave signal bundle for the PSRAM bridge.
interface wb_psram_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wb_psram.sv
// Wishbone slave that splits 32-bit accesses into timed halfword cycles on the async PSRAM bus.
// Define WB_PSRAM_CRE_INIT_EN to write cr_value into the PSRAM configuration register after reset.
module wb_psram
    import wb_psram_pkg::*;
#(
    parameter int               rd_wait  = 4,
    parameter int               wr_wait  = 4,
    parameter logic [ADR_W-1:0] cr_value = 23'h001D1F
) (
    input  logic             clk,
    input  logic             reset,
    wb_psram_if.slave        wb,
    output logic [ADR_W-1:0] sram_adr,
    inout  wire  [15:0]      sram_dat,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_ub_n,
    output logic             sram_lb_n,
    output logic             sram_clk,
    output logic             sram_adv_n,
    output logic             sram_cre,
    output logic             flash_cs_n
);

    localparam int            CW      = cnt_width(rd_wait, wr_wait);
    localparam logic [CW-1:0] RD_LOAD = CW'(rd_wait - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(wr_wait - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [21:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [HW_W-1:0]   hw_q, hw_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [31:0]       rdo_q, rdo_d;

    // Pin drivers are registered from the next state so the async part never sees decode glitches.
    logic [ADR_W-1:0]  sram_adr_q, sram_adr_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              drive_q, drive_d;
    logic [15:0]       dout_q, dout_d;

    logic              cfg_pend;
    logic              unused_bits;

`ifdef WB_PSRAM_CRE_INIT_EN
    logic              cfg_done_q, cfg_done_d;
    logic              cre_q, cre_d;
    assign cfg_pend = !cfg_done_q;
    assign sram_cre = cre_q;
`else
    assign cfg_pend = 1'b0;
    assign sram_cre = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        hw_d    = hw_q;
        rdat_d  = rdat_q;
        rdo_d   = rdo_q;
`ifdef WB_PSRAM_CRE_INIT_EN
        cfg_done_d = cfg_done_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_pend) begin
`ifdef WB_PSRAM_CRE_INIT_EN
                    state_d = ST_CFG_SETUP;
`endif
                end else if (wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_ack_o) begin
                    adr_d = wb.wb_adr_i[23:2];
                    dat_d = wb.wb_dat_i;
                    sel_d = wb.wb_sel_i;
                    we_d  = wb.wb_we_i;
                    // Writes skip halfwords with no byte lanes selected.
                    if (!wb.wb_we_i || (wb.wb_sel_i[3:2] != 2'b00)) begin
                        hw_d    = '0;
                        state_d = ST_SETUP;
                    end else if (wb.wb_sel_i[1:0] != 2'b00) begin
                        hw_d    = HW_W'(1);
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = we_q ? WR_LOAD : RD_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (hw_q == '0) rdat_d[31:16] = sram_dat;
                        else            rdat_d[15:0]  = sram_dat;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if ((hw_q == '0) && (!we_q || (sel_q[1:0] != 2'b00))) begin
                    hw_d    = HW_W'(1);
                    state_d = ST_SETUP;
                end else begin
                    if (!we_q) rdo_d = rdat_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: state_d = ST_IDLE;
`ifdef WB_PSRAM_CRE_INIT_EN
            ST_CFG_SETUP: begin
                cnt_d   = WR_LOAD;
                state_d = ST_CFG_STROBE;
            end
            ST_CFG_STROBE: begin
                if (cnt_q == '0) state_d = ST_CFG_HOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_CFG_HOLD: begin
                cfg_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        sram_adr_d = sram_adr_q;
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        ub_n_d     = 1'b1;
        lb_n_d     = 1'b1;
        drive_d    = 1'b0;
        dout_d     = dout_q;
`ifdef WB_PSRAM_CRE_INIT_EN
        cre_d      = 1'b0;
`endif
        case (state_d)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                sram_adr_d = {adr_d, hw_d};
                ce_n_d     = 1'b0;
                if (we_d) begin
                    ub_n_d  = hw_d[0] ? ~sel_d[1] : ~sel_d[3];
                    lb_n_d  = hw_d[0] ? ~sel_d[0] : ~sel_d[2];
                    drive_d = 1'b1;
                    dout_d  = hw_d[0] ? dat_d[15:0] : dat_d[31:16];
                    we_n_d  = (state_d != ST_STROBE);
                end else begin
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                    oe_n_d = (state_d != ST_STROBE);
                end
            end
`ifdef WB_PSRAM_CRE_INIT_EN
            ST_CFG_SETUP, ST_CFG_STROBE, ST_CFG_HOLD: begin
                sram_adr_d = cr_value;
                ce_n_d     = 1'b0;
                cre_d      = 1'b1;
                we_n_d     = (state_d != ST_CFG_STROBE);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            hw_q       <= '0;
            rdat_q     <= '0;
            rdo_q      <= '0;
            sram_adr_q <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            dout_q     <= '0;
`ifdef WB_PSRAM_CRE_INIT_EN
            cfg_done_q <= 1'b0;
            cre_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            hw_q       <= hw_d;
            rdat_q     <= rdat_d;
            rdo_q      <= rdo_d;
            sram_adr_q <= sram_adr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            drive_q    <= drive_d;
            dout_q     <= dout_d;
`ifdef WB_PSRAM_CRE_INIT_EN
            cfg_done_q <= cfg_done_d;
            cre_q      <= cre_d;
`endif
        end
    end

    // A master that drops cyc before the access finishes gets no ack.
    assign wb.wb_ack_o = (state_q == ST_ACK) && wb.wb_cyc_i;
    assign wb.wb_dat_o = rdo_q;

    assign sram_dat   = drive_q ? dout_q : 16'hzzzz;
    assign sram_adr   = sram_adr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_clk   = 1'b0;
    assign sram_adv_n = 1'b0;
    assign flash_cs_n = 1'b1;

    assign unused_bits = ^{wb.wb_adr_i[31:24], wb.wb_adr_i[1:0], cr_value};

endmodule

// File: tb/tb_wb_psram.sv
// Self-checking bench for wb_psram: PSRAM model, external-write scoreboard and read-data queue.
module tb_wb_psram;

    localparam int RD_WAIT = 4;
    localparam int WR_WAIT = 4;
`ifdef WB_PSRAM_CRE_INIT_EN
    localparam int CFG_EXTRA = WR_WAIT + 3;
`else
    localparam int CFG_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    wb_psram_if  wb();
    wire  [15:0] sram_dat;
    logic [22:0] sram_adr;
    logic        ce_n, oe_n, we_n, ub_n, lb_n, sram_clk, adv_n, cre, flash_cs_n;

    always #5 clk = ~clk;

    wb_psram dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wb),
        .sram_adr   (sram_adr),
        .sram_dat   (sram_dat),
        .sram_ce_n  (ce_n),
        .sram_oe_n  (oe_n),
        .sram_we_n  (we_n),
        .sram_ub_n  (ub_n),
        .sram_lb_n  (lb_n),
        .sram_clk   (sram_clk),
        .sram_adv_n (adv_n),
        .sram_cre   (cre),
        .flash_cs_n (flash_cs_n)
    );

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu (sram_dat[g]);
    end

    logic [15:0] mem    [0:255];
    logic [15:0] shadow [0:255];

    assign sram_dat = (ce_n === 1'b0 && oe_n === 1'b0 && we_n === 1'b1) ? mem[sram_adr[7:0]] : 16'hzzzz;

    typedef struct {
        logic        cre;
        logic [22:0] adr;
        logic [15:0] dat;
        logic        ub_n;
        logic        lb_n;
    } ext_wr_t;

    ext_wr_t     exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    int checks = 0;
    int errors = 0;
    int ce_cycles = 0, ack_count = 0, rd_pulses = 0, wr_pulses = 0;
    int we_len = 0, oe_len = 0;
    logic we_prev = 1'b1, oe_prev = 1'b1;

    always @(negedge clk) begin : monitor
        ext_wr_t e;
        if (ce_n === 1'b0) ce_cycles++;
        if (wb.wb_ack_o === 1'b1) ack_count++;
        if (we_n === 1'b0) we_len++;
        if (oe_n === 1'b0) oe_len++;
        if (we_prev === 1'b0 && we_n === 1'b1) begin
            if (!reset) begin
                wr_pulses++;
                checks++;
                if (we_len != WR_WAIT) begin
                    errors++;
                    $display("FAIL we_width got %0d want %0d", we_len, WR_WAIT);
                end
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write adr %h dat %h cre %b want none", sram_adr, sram_dat, cre);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (cre !== e.cre || sram_adr !== e.adr || ub_n !== e.ub_n || lb_n !== e.lb_n ||
                        sram_dat !== (e.cre ? 16'hffff : e.dat)) begin
                        errors++;
                        $display("FAIL ext_write got cre %b adr %h dat %h ub %b lb %b want cre %b adr %h dat %h ub %b lb %b",
                                 cre, sram_adr, sram_dat, ub_n, lb_n, e.cre, e.adr, e.dat, e.ub_n, e.lb_n);
                    end
                end
                if (cre !== 1'b1) begin
                    if (ub_n === 1'b0) mem[sram_adr[7:0]][15:8] = sram_dat[15:8];
                    if (lb_n === 1'b0) mem[sram_adr[7:0]][7:0]  = sram_dat[7:0];
                end
            end
            we_len = 0;
        end
        if (oe_prev === 1'b0 && oe_n === 1'b1) begin
            if (!reset) begin
                rd_pulses++;
                checks++;
                if (oe_len != RD_WAIT) begin
                    errors++;
                    $display("FAIL oe_width got %0d want %0d", oe_len, RD_WAIT);
                end
            end
            oe_len = 0;
        end
        we_prev = we_n;
        oe_prev = oe_n;
    end

    task automatic push_cfg_expect();
`ifdef WB_PSRAM_CRE_INIT_EN
        exp_wr_q.push_back('{cre: 1'b1, adr: 23'h001D1F, dat: 16'hffff, ub_n: 1'b1, lb_n: 1'b1});
`endif
    endtask

    // Records the halfword writes the bus should carry and updates the bench's memory image.
    task automatic expect_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [22:0] ha;
        int          h;
        ha = {adr[23:2], 1'b0};
        h  = int'(adr[8:2]) * 2;
        if (sel[3:2] != 2'b00) begin
            exp_wr_q.push_back('{cre: 1'b0, adr: ha, dat: dat[31:16], ub_n: ~sel[3], lb_n: ~sel[2]});
            if (sel[3]) shadow[h][15:8] = dat[31:24];
            if (sel[2]) shadow[h][7:0]  = dat[23:16];
        end
        if (sel[1:0] != 2'b00) begin
            exp_wr_q.push_back('{cre: 1'b0, adr: ha | 23'd1, dat: dat[15:0], ub_n: ~sel[1], lb_n: ~sel[0]});
            if (sel[1]) shadow[h + 1][15:8] = dat[15:8];
            if (sel[0]) shadow[h + 1][7:0]  = dat[7:0];
        end
    endtask

    task automatic expect_read(input logic [31:0] adr);
        int h;
        h = int'(adr[8:2]) * 2;
        exp_rd_q.push_back({shadow[h], shadow[h + 1]});
    endtask

    // Entered and left at posedge+1; lat counts clock edges from driving the request to seeing ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int lat, output logic [31:0] rdat,
                             output bit got_ack);
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_we_i  = we;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        lat     = 0;
        got_ack = 1'b0;
        while (!got_ack && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wb.wb_ack_o === 1'b1) got_ack = 1'b1;
        end
        rdat = wb.wb_dat_o;
        @(posedge clk);
        #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int exp_lat);
        int          lat;
        logic [31:0] rdat;
        bit          ok;
        expect_write(adr, dat, sel);
        wb_access(1'b1, adr, dat, sel, lat, rdat, ok);
        checks++;
        if (!ok || lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d ack %b want %0d", name, lat, ok, exp_lat);
        end
    endtask

    task automatic do_read(input string name, input logic [31:0] adr, input int exp_lat);
        int          lat;
        logic [31:0] rdat;
        logic [31:0] exp;
        bit          ok;
        expect_read(adr);
        wb_access(1'b0, adr, 32'h0, 4'hf, lat, rdat, ok);
        checks++;
        if (!ok || lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d ack %b want %0d", name, lat, ok, exp_lat);
        end
        exp = exp_rd_q.pop_front();
        checks++;
        if (rdat !== exp) begin
            errors++;
            $display("FAIL %s_data got %h want %h", name, rdat, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n});
        end
        checks++;
        if (sram_adr !== 23'd0 || sram_dat !== 16'hffff) begin
            errors++;
            $display("FAIL reset_bus got adr %h dat %h want adr 0 dat released", sram_adr, sram_dat);
        end
        checks++;
        if (wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_wb got ack %b dat %h want 0 0", wb.wb_ack_o, wb.wb_dat_o);
        end
        checks++;
        if ({cre, sram_clk, adv_n, flash_cs_n} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ties got %b want 0001", {cre, sram_clk, adv_n, flash_cs_n});
        end
        @(posedge clk);
        #1;
        push_cfg_expect();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_full_word();
        int rp0, wp0;
        wp0 = wr_pulses;
        do_write("full_write", 32'h4000_0010, 32'h1234_5678, 4'b1111, 13);
        checks++;
        if (wr_pulses - wp0 != 2 || shadow[8] !== 16'h1234 || shadow[9] !== 16'h5678) begin
            errors++;
            $display("FAIL full_write_pulses got %0d want 2", wr_pulses - wp0);
        end
        rp0 = rd_pulses;
        do_read("full_read", 32'h4000_0010, 13);
        checks++;
        if (rd_pulses - rp0 != 2) begin
            errors++;
            $display("FAIL full_read_pulses got %0d want 2", rd_pulses - rp0);
        end
    endtask

    task automatic test_partial_write();
        int wp0, ce0;
        wp0 = wr_pulses;
        ce0 = ce_cycles;
        do_write("partial_write", 32'h4000_0020, 32'hAAAA_BBBB, 4'b0011, 7);
        checks++;
        if (wr_pulses - wp0 != 1 || ce_cycles - ce0 != WR_WAIT + 2) begin
            errors++;
            $display("FAIL partial_write_cycles got pulses %0d ce %0d want 1 %0d",
                     wr_pulses - wp0, ce_cycles - ce0, WR_WAIT + 2);
        end
        checks++;
        if (mem[8'h10] !== 16'h1010 || mem[8'h11] !== 16'hBBBB) begin
            errors++;
            $display("FAIL partial_write_mem got %h %h want 1010 bbbb", mem[8'h10], mem[8'h11]);
        end
    endtask

    task automatic test_null_write();
        int wp0, ce0;
        wp0 = wr_pulses;
        ce0 = ce_cycles;
        do_write("null_write", 32'h4000_0030, 32'hFFFF_FFFF, 4'b0000, 1);
        checks++;
        if (wr_pulses != wp0 || ce_cycles != ce0) begin
            errors++;
            $display("FAIL null_write_bus got pulses %0d ce %0d want 0 0", wr_pulses - wp0, ce_cycles - ce0);
        end
    endtask

    task automatic test_reset_mid_read();
        int ack0;
        ack0 = ack_count;
        wb.wb_adr_i = 32'h4000_0020;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 4'hf;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        push_cfg_expect();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || sram_dat !== 16'hffff || wb.wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got strobes %b dat %h ack %b want 11111 released 0",
                     {ce_n, oe_n, we_n, ub_n, lb_n}, sram_dat, wb.wb_ack_o);
        end
        #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (ack_count != ack0) begin
            errors++;
            $display("FAIL mid_reset_ack got %0d acks want 0", ack_count - ack0);
        end
        do_read("post_reset_read", 32'h4000_0010, 13);
    endtask

    task automatic test_abort();
        int ack0, rp0;
        ack0 = ack_count;
        rp0  = rd_pulses;
        wb.wb_adr_i = 32'h4000_0020;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 4'hf;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (ack_count != ack0 || rd_pulses - rp0 != 2) begin
            errors++;
            $display("FAIL abort got acks %0d pulses %0d want 0 2", ack_count - ack0, rd_pulses - rp0);
        end
        do_write("after_abort_write", 32'h4000_0030, 32'hDEAD_BEEF, 4'b1100, 7);
        do_read("after_abort_read", 32'h4000_0030, 13);
    endtask

    task automatic test_back_to_back();
        do_read("b2b_read0", 32'h4000_0010, 13);
        do_read("b2b_read1", 32'h4000_0020, 13);
        do_write("b2b_write", 32'h4000_0040, 32'h0102_0304, 4'b0110, 13);
        do_read("b2b_read2", 32'h4000_0040, 13);
    endtask

    task automatic test_cre_stall();
        reset = 1'b1;
        push_cfg_expect();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_read("cre_stall_read", 32'h4000_0010, 13 + CFG_EXTRA);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(16'h1000 + i);
            shadow[i] = 16'(16'h1000 + i);
        end
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        reset       = 1'b1;

        test_reset();
        test_full_word();
        test_partial_write();
        test_null_write();
        test_reset_mid_read();
        test_abort();
        test_back_to_back();
        test_cre_stall();

        repeat (4) @(posedge clk);
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got writes %0d reads %0d want 0 0",
                     exp_wr_q.size(), exp_rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_psram.md
Name: wb_psram

Overview:
- Wishbone slave that fronts the Nexys2 16-bit asynchronous PSRAM (Micron CellularRAM).
- Turns each 32-bit Wishbone access into one or two timed halfword cycles on the external bus.
- Sits on interconnect slave 0 (address window 0x4xxxxxxx) and replaces the interim block-RAM stand-in.
- Also parks the shared flash device so it never contends for the data bus.

Parameters:
- rd_wait, 4: cycles oe_n held low per halfword read. Must be ≥1; 4 × 20 ns covers 70 ns parts at 50 MHz.
- wr_wait, 4: cycles we_n held low per halfword write. Must be ≥1.
- cr_value, 23'h001D1F: word driven on sram_adr during the configuration-register write (feature-gated).

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- wb_adr_i in 32: byte address; bits [23:2] used.
- wb_dat_i in 32: write data.
- wb_dat_o out 32: read data.
- wb_sel_i in 4: byte selects.
- wb_stb_i in 1: Wishbone strobe.
- wb_cyc_i in 1: Wishbone cycle.
- wb_we_i in 1: write enable.
- wb_ack_o out 1: single-cycle acknowledge.
- sram_adr out 23: halfword address.
- sram_dat inout 16: data bus.
- sram_ce_n out 1: chip enable.
- sram_oe_n out 1: output enable.
- sram_we_n out 1: write enable.
- sram_ub_n out 1: upper-byte enable.
- sram_lb_n out 1: lower-byte enable.
- sram_clk out 1: tied 0 (asynchronous mode).
- sram_adv_n out 1: tied 0.
- sram_cre out 1: configuration-register enable.
- flash_cs_n out 1: tied 1.

Behaviour:
- Reset values: ce_n, oe_n, we_n, ub_n, lb_n all 1; sram_adr 0; sram_dat high-Z; wb_ack_o 0; wb_dat_o 0; sram_cre 0.
- Reset is synchronous and takes effect mid-operation: FSM to IDLE, all strobes high, bus released, no ack for the aborted access.
- Endianness is big: halfword 0 is at {wb_adr_i[23:2],1'b0} and carries data[31:16] with sel[3:2]; halfword 1 is at {wb_adr_i[23:2],1'b1} and carries data[15:0] with sel[1:0].
- ub_n/lb_n are the inverted sel pair for writes; both 0 for reads.
- FSM states: IDLE, SETUP, STROBE, HOLD, ACK (plus CFG states when the optional feature is compiled in).
- IDLE: when wb_cyc_i & wb_stb_i & ~wb_ack_o, latch address, data, sel and we, then pick the first halfword.
  - Reads: always both halfwords.
  - Writes: skip any halfword whose sel pair is 00.
  - Write with sel=0000: go straight to ACK with no external cycle.
- SETUP (1 cycle): sram_adr valid, ce_n=0, strobes high; for writes, sram_dat driven.
- STROBE (rd_wait or wr_wait cycles, down-counter): oe_n=0 or we_n=0. On the final read STROBE cycle, capture sram_dat into the matching half of the read register.
- HOLD (1 cycle): strobes high, ce_n=0, write data still driven. Then SETUP for the next pending halfword, otherwise ACK.
- ACK (1 cycle): wb_ack_o=1 only if wb_cyc_i is still high; the master-abort case completes silently. wb_dat_o updates in this cycle (reads only) and holds until the next read. Next state is IDLE.
- Latency from request sampled to ack: n × (wait+2) + 1, where n is the number of halfwords.
  - 32-bit read with rd_wait=4: 13 cycles.
  - Single-halfword write with wr_wait=4: 7 cycles.
- A back-to-back request is not accepted in the ACK cycle; earliest acceptance is the following IDLE cycle.
- sram_dat is driven only in SETUP, STROBE and HOLD of write halfwords; high-Z otherwise.

Optional Feature:
- Macro: WB_PSRAM_CRE_INIT_EN.
- Defined: after reset, FSM runs CFG_SETUP → CFG_STROBE (wr_wait cycles) → CFG_HOLD → IDLE.
  - sram_adr=cr_value, sram_cre=1, ce_n=0, we_n=0 in strobe; ub_n/lb_n=1; data not driven.
  - Wishbone requests arriving meanwhile stall, with no ack until the config write is done.
- Undefined: sram_cre tied 0; FSM leaves reset directly in IDLE.

Decomposition:
- Shared package: state encoding localparams, HW_COUNT=2, counter width clog2(max(rd_wait,wr_wait)+1).
- No sub-module warranted: FSM, wait counter and tristate are inline in one module.

Test Plan:
- Write 0x12345678 with sel=1111 to 0x40000010, then read it back.
  - Expect halfword 0x1234 at adr 8, then 0x5678 at adr 9.
  - Each we_n low pulse lasts exactly 4 cycles; read returns 0x12345678; ack 13 cycles after request.
- Write sel=0011 data 0xAAAABBBB to 0x40000020.
  - Expect exactly one external cycle at adr 0x11 with ub_n=lb_n=0, driving 0xBBBB.
  - Ack after 7 cycles; halfword 0x10 untouched in the PSRAM model.
- Write sel=0000.
  - Expect ack one cycle after acceptance; ce_n never asserted.
- Assert reset in the 2nd STROBE cycle of a read.
  - Next edge: all strobes high, sram_dat high-Z, wb_ack_o stays 0; a following read completes normally.
- Drop wb_cyc_i during the HOLD of halfword 0.
  - Halfword 1 still runs; no ack pulse; next request is accepted normally.
- With WB_PSRAM_CRE_INIT_EN, issue a read right after reset.
  - First external cycle has sram_cre=1, adr=0x001D1F, 4-cycle we_n pulse.
  - Read ack arrives only after CFG_HOLD.
